// File: rtl/uart_rx_fsmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and helpers for the uart_rx_fsmd receiver slice.
//   rx_state_t      : receiver FSM states
//   PAR_*           : parity mode encodings for cfg_parity
//   clamp_data_bits : folds a requested data-bit count into 5..max_bits
//   parity_enabled  : true for the even/odd parity modes
// ---------------------------------------------------------------------------
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Out-of-range requests are folded to the nearest legal count rather than
   // rejected, so a bad register write still yields a usable frame format.
   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                  input logic [3:0] max_bits);
      logic [3:0] result;
      result = req;
      if (req < 4'd5) begin
         result = 4'd5;
      end else if (req > max_bits) begin
         result = max_bits;
      end
      return result;
   endfunction

   // Mode 2'b11 is reserved and behaves like no parity.
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode != PAR_NONE) && (mode != 2'b11);
   endfunction

endpackage

// File: rtl/uart_rx_fsmd_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fsmd_if
// Output handshake bundle between the receiver and its consumer.
//   rx_valid/rx_ready : valid/ready handshake for one received frame
//   rx_data           : received word, LSB-aligned
//   parity_err, frame_err, break_det : per-frame status of the held word
//   overrun           : sticky "a completed frame was dropped"
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_fsmd_if #(
   parameter int DATA_MAX = 9
);

   logic                rx_valid;
   logic                rx_ready;
   logic [DATA_MAX-1:0] rx_data;
   logic                parity_err;
   logic                frame_err;
   logic                break_det;
   logic                overrun;

   modport master (
      output rx_valid,
      output rx_data,
      output parity_err,
      output frame_err,
      output break_det,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      input  parity_err,
      input  frame_err,
      input  break_det,
      input  overrun,
      output rx_ready
   );

endinterface

// File: rtl/uart_rx_fsmd_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Line conditioning for the UART receiver: 2-flop synchronizer, in-bit tick
// counter and 3-sample majority voter.
//   clk, rst     : clock, synchronous active-high reset
//   sample_tick  : one-clk strobe at OVS x baud
//   rx           : raw asynchronous serial line
//   cnt_clr      : restart the bit counter on the next tick (state entry)
//   rx_s         : synchronized line
//   bit_val      : 2-of-3 majority, meaningful while decide is high
//   decide       : strobe on the tick where the bit value is decided
//   bit_end      : strobe on the last tick of a bit period
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
   parameter int OVS   = 16,
   parameter int CNT_W = $clog2(OVS)
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic rx,
   input  logic cnt_clr,
   output logic rx_s,
   output logic bit_val,
   output logic decide,
   output logic bit_end
);

   logic             rx_meta;
   logic [CNT_W-1:0] cnt;
   logic             samp_a;
   logic             samp_b;

   // Two-flop synchronizer; resets to the idle-high line level so a reset
   // never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Tick counter within one bit period. The FSM clears it whenever it
   // changes state, so every state starts counting from 0; within a state it
   // simply wraps at OVS-1 to roll into the next bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (sample_tick) begin
         if (cnt_clr || (cnt == CNT_W'(OVS - 1))) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Capture the two samples just before and at mid-bit; the third sample
   // is the live line on the decision tick itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else if (sample_tick) begin
         if (cnt == CNT_W'(OVS/2 - 1)) begin
            samp_a <= rx_s;
         end
         if (cnt == CNT_W'(OVS/2)) begin
            samp_b <= rx_s;
         end
      end
   end

   assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign decide  = sample_tick && (cnt == CNT_W'(OVS/2 + 1));
   assign bit_end = sample_tick && (cnt == CNT_W'(OVS - 1));

endmodule

// File: rtl/uart_rx_fsmd.sv
// ---------------------------------------------------------------------------
// uart_rx_fsmd
// UART receiver with runtime frame format (5..DATA_MAX data bits,
// none/even/odd parity, 1 or 2 stop bits) and a valid/ready output register.
//   clk, rst        : clock, synchronous active-high reset
//   sample_tick     : one-clk strobe at OVS x baud
//   rx              : asynchronous serial line, idles high
//   cfg_data_bits   : data bits per frame (clamped to 5..DATA_MAX)
//   cfg_parity      : 00 none, 01 even, 10 odd, 11 none
//   cfg_stop2       : 1 selects two stop bits
//   busy            : FSM is not in IDLE
//   host            : output handshake (rx_valid/rx_ready, data, flags)
// ---------------------------------------------------------------------------
module uart_rx_fsmd
   import uart_rx_pkg::*;
#(
   parameter int DATA_MAX = 9,
   parameter int OVS      = 16,
   parameter int CNT_W    = $clog2(OVS)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic [3:0] cfg_data_bits,
   input  logic [1:0] cfg_parity,
   input  logic       cfg_stop2,
   output logic       busy,
   uart_rx_fsmd_if.master host
);

   rx_state_t           state;
   rx_state_t           state_next;
   logic                rx_s;
   logic                bit_val;
   logic                decide;
   logic                bit_end;
   logic                cnt_clr;
   logic                start_seen;
   logic                frame_done;

   logic [3:0]          data_bits_l;
   logic [1:0]          parity_l;
   logic                stop2_l;
   logic [3:0]          idx;
   logic [DATA_MAX-1:0] shift;
   logic                par_acc;
   logic                par_err_r;
   logic                frame_err_r;
   logic                all_zero;
   logic                stop_second;

   logic                valid_q;
   logic [DATA_MAX-1:0] data_q;
   logic                par_err_q;
   logic                frame_err_q;
   logic                break_q;
   logic                overrun_q;
   logic                accept;

   uart_rx_sampler #(
      .OVS   (OVS),
      .CNT_W (CNT_W)
   ) u_sampler (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx),
      .cnt_clr     (cnt_clr),
      .rx_s        (rx_s),
      .bit_val     (bit_val),
      .decide      (decide),
      .bit_end     (bit_end)
   );

   assign start_seen = (state == IDLE) && sample_tick && !rx_s;
   assign frame_done = (state == STOP) && decide && (!stop2_l || stop_second);
   assign accept     = valid_q && host.rx_ready;
   assign cnt_clr    = (state == IDLE) || (state_next != state);
   assign busy       = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The final stop bit leaves for IDLE on its decision
   // tick, half a bit early, so a back-to-back start edge is not missed.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start_seen) begin
               state_next = START;
            end
         end
         START: begin
            if (decide && bit_val) begin
               state_next = IDLE;
            end else if (bit_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end && (idx == data_bits_l - 4'd1)) begin
               state_next = parity_enabled(parity_l) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (frame_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame datapath: format latch, shift register, running parity and the
   // error/break trackers. Everything is re-initialised when a start bit is
   // seen so the output register only ever sees this frame's history.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_bits_l <= 4'd5;
         parity_l    <= PAR_NONE;
         stop2_l     <= 1'b0;
         idx         <= '0;
         shift       <= '0;
         par_acc     <= 1'b0;
         par_err_r   <= 1'b0;
         frame_err_r <= 1'b0;
         all_zero    <= 1'b1;
         stop_second <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_seen) begin
                  data_bits_l <= clamp_data_bits(cfg_data_bits, 4'(DATA_MAX));
                  parity_l    <= cfg_parity;
                  stop2_l     <= cfg_stop2;
                  idx         <= '0;
                  shift       <= '0;
                  par_acc     <= 1'b0;
                  par_err_r   <= 1'b0;
                  frame_err_r <= 1'b0;
                  all_zero    <= 1'b1;
                  stop_second <= 1'b0;
               end
            end
            DATA: begin
               if (decide) begin
                  for (int i = 0; i < DATA_MAX; i++) begin
                     if (idx == 4'(i)) begin
                        shift[i] <= bit_val;
                     end
                  end
                  par_acc  <= par_acc ^ bit_val;
                  all_zero <= all_zero & ~bit_val;
               end
               if (bit_end) begin
                  idx <= idx + 4'd1;
               end
            end
            PARITY: begin
               if (decide) begin
                  par_err_r <= (parity_l == PAR_EVEN) ? (par_acc ^ bit_val)
                                                      : ~(par_acc ^ bit_val);
                  all_zero  <= all_zero & ~bit_val;
               end
            end
            STOP: begin
               if (decide) begin
                  frame_err_r <= frame_err_r | ~bit_val;
                  all_zero    <= all_zero & ~bit_val;
               end
               if (bit_end) begin
                  stop_second <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output register. A completed frame is loaded when the register is free
   // or being drained this very cycle; otherwise it is dropped and overrun
   // is flagged. The final stop bit's own value is folded in directly since
   // it is decided on the completion cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         data_q      <= '0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         break_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (frame_done && (!valid_q || host.rx_ready)) begin
            valid_q     <= 1'b1;
            data_q      <= shift;
            par_err_q   <= par_err_r;
            frame_err_q <= frame_err_r | ~bit_val;
            break_q     <= all_zero & ~bit_val;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
         if (frame_done && valid_q && !host.rx_ready) begin
            overrun_q <= 1'b1;
         end else if (accept) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign host.rx_valid   = valid_q;
   assign host.rx_data    = data_q;
   assign host.parity_err = par_err_q;
   assign host.frame_err  = frame_err_q;
   assign host.break_det  = break_q;
   assign host.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsmd
// Directed bench for uart_rx_fsmd: OVS = 16, one sample tick every 4 clk,
// so one bit period is 64 clk. Frames are driven bit by bit on rx and the
// accepted words are captured by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsmd;
   import uart_rx_pkg::*;

   localparam int DATA_MAX = 9;
   localparam int OVS      = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OVS * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick = 1'b0;
   logic       rx;
   logic [3:0] cfg_data_bits;
   logic [1:0] cfg_parity;
   logic       cfg_stop2;
   logic       busy;

   int check_count  = 0;
   int pass_count   = 0;
   int accept_count = 0;
   int accepts_before;

   logic [DATA_MAX-1:0] cap_data = '0;
   logic                cap_perr = 1'b0;
   logic                cap_ferr = 1'b0;
   logic                cap_brk  = 1'b0;

   uart_rx_fsmd_if #(.DATA_MAX(DATA_MAX)) rx_if ();

   uart_rx_fsmd #(
      .DATA_MAX (DATA_MAX),
      .OVS      (OVS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sample_tick   (sample_tick),
      .rx            (rx),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .busy          (busy),
      .host          (rx_if)
   );

   // 100 MHz-style clock.
   always #5 clk = ~clk;

   // Baud-rate tick: one clk high out of every TICK_DIV, changed on negedge.
   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         sample_tick = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
      end
   end

   // Capture every handshake so frames sent with rx_ready = 1 can be
   // inspected after the fact.
   always @(negedge clk) begin
      if (!rst && rx_if.rx_valid && rx_if.rx_ready) begin
         accept_count = accept_count + 1;
         cap_data     = rx_if.rx_data;
         cap_perr     = rx_if.parity_err;
         cap_ferr     = rx_if.frame_err;
         cap_brk      = rx_if.break_det;
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      check_count = check_count + 1;
      if (observed === expected) begin
         pass_count = pass_count + 1;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit period; with glitch set, the line is inverted for one tick
   // period around the decision samples.
   task automatic sendBit(input logic v, input bit glitch);
      rx = v;
      if (glitch) begin
         waitClks(36);
         rx = ~v;
         waitClks(TICK_DIV);
         rx = v;
         waitClks(BIT_CLKS - 36 - TICK_DIV);
      end else begin
         waitClks(BIT_CLKS);
      end
   endtask

   // Drive one complete frame: start, data LSB first, optional parity,
   // one or two stop bits.
   task automatic applyStimulus(input logic [8:0] data, input int nbits,
                                input logic [1:0] par, input logic stop2,
                                input bit flip_par, input int glitch_idx);
      logic p;
      cfg_data_bits = 4'(nbits);
      cfg_parity    = par;
      cfg_stop2     = stop2;
      sendBit(1'b0, 1'b0);
      p = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         sendBit(data[i], i == glitch_idx);
         p = p ^ data[i];
      end
      if (par == PAR_EVEN || par == PAR_ODD) begin
         if (par == PAR_ODD) p = ~p;
         if (flip_par) p = ~p;
         sendBit(p, 1'b0);
      end
      sendBit(1'b1, 1'b0);
      if (stop2) sendBit(1'b1, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      rx             = 1'b1;
      rx_if.rx_ready = 1'b1;
      cfg_data_bits  = 4'd8;
      cfg_parity     = PAR_NONE;
      cfg_stop2      = 1'b0;
      waitClks(5);

      $display("[TB] reset values");
      checkOutput("rst_valid",   16'(rx_if.rx_valid),   16'h0);
      checkOutput("rst_data",    16'(rx_if.rx_data),    16'h0);
      checkOutput("rst_perr",    16'(rx_if.parity_err), 16'h0);
      checkOutput("rst_ferr",    16'(rx_if.frame_err),  16'h0);
      checkOutput("rst_brk",     16'(rx_if.break_det),  16'h0);
      checkOutput("rst_overrun", 16'(rx_if.overrun),    16'h0);
      checkOutput("rst_busy",    16'(busy),             16'h0);
      rst = 1'b0;
      waitClks(BIT_CLKS);

      $display("[TB] 8N1 0xA5");
      accepts_before = accept_count;
      applyStimulus(9'h0A5, 8, PAR_NONE, 1'b0, 1'b0, -1);
      waitClks(BIT_CLKS);
      checkOutput("8n1_accepts", 16'(accept_count - accepts_before), 16'd1);
      checkOutput("8n1_data",    16'(cap_data), 16'h0A5);
      checkOutput("8n1_perr",    16'(cap_perr), 16'h0);
      checkOutput("8n1_ferr",    16'(cap_ferr), 16'h0);
      checkOutput("8n1_brk",     16'(cap_brk),  16'h0);

      $display("[TB] 7E2 0x35 with bad parity");
      accepts_before = accept_count;
      applyStimulus(9'h035, 7, PAR_EVEN, 1'b1, 1'b1, -1);
      waitClks(BIT_CLKS);
      checkOutput("7e2_accepts", 16'(accept_count - accepts_before), 16'd1);
      checkOutput("7e2_data",    16'(cap_data), 16'h035);
      checkOutput("7e2_perr",    16'(cap_perr), 16'h1);
      checkOutput("7e2_ferr",    16'(cap_ferr), 16'h0);

      $display("[TB] false start");
      cfg_data_bits  = 4'd8;
      cfg_parity     = PAR_NONE;
      cfg_stop2      = 1'b0;
      accepts_before = accept_count;
      rx = 1'b0;
      waitClks(3 * TICK_DIV);
      checkOutput("false_busy_hi", 16'(busy), 16'h1);
      rx = 1'b1;
      waitClks(2 * BIT_CLKS);
      checkOutput("false_busy_lo", 16'(busy), 16'h0);
      checkOutput("false_accepts", 16'(accept_count - accepts_before), 16'd0);
      checkOutput("false_valid",   16'(rx_if.rx_valid), 16'h0);

      $display("[TB] overrun with rx_ready low");
      rx_if.rx_ready = 1'b0;
      applyStimulus(9'h011, 8, PAR_NONE, 1'b0, 1'b0, -1);
      checkOutput("ovr_valid1", 16'(rx_if.rx_valid), 16'h1);
      checkOutput("ovr_data1",  16'(rx_if.rx_data),  16'h011);
      applyStimulus(9'h022, 8, PAR_NONE, 1'b0, 1'b0, -1);
      checkOutput("ovr_data2",  16'(rx_if.rx_data),  16'h011);
      checkOutput("ovr_flag",   16'(rx_if.overrun),  16'h1);
      checkOutput("ovr_valid2", 16'(rx_if.rx_valid), 16'h1);
      rx_if.rx_ready = 1'b1;
      waitClks(1);
      checkOutput("ovr_valid_clr", 16'(rx_if.rx_valid), 16'h0);
      checkOutput("ovr_flag_clr",  16'(rx_if.overrun),  16'h0);
      waitClks(BIT_CLKS);

      $display("[TB] 8O1 break");
      cfg_data_bits  = 4'd8;
      cfg_parity     = PAR_ODD;
      cfg_stop2      = 1'b0;
      accepts_before = accept_count;
      rx = 1'b0;
      waitClks(12 * BIT_CLKS);
      checkOutput("brk_accepts", 16'(accept_count - accepts_before), 16'd1);
      checkOutput("brk_data",    16'(cap_data), 16'h000);
      checkOutput("brk_brk",     16'(cap_brk),  16'h1);
      checkOutput("brk_ferr",    16'(cap_ferr), 16'h1);
      checkOutput("brk_perr",    16'(cap_perr), 16'h1);
      rx = 1'b1;
      waitClks(14 * BIT_CLKS);
      checkOutput("brk_idle", 16'(busy), 16'h0);

      $display("[TB] 8O1 0x3C with glitch on bit 2");
      accepts_before = accept_count;
      applyStimulus(9'h03C, 8, PAR_ODD, 1'b0, 1'b0, 2);
      waitClks(BIT_CLKS);
      checkOutput("glitch_accepts", 16'(accept_count - accepts_before), 16'd1);
      checkOutput("glitch_data",    16'(cap_data), 16'h03C);
      checkOutput("glitch_perr",    16'(cap_perr), 16'h0);
      checkOutput("glitch_ferr",    16'(cap_ferr), 16'h0);

      $display("[TB] reset during data bit 4");
      cfg_data_bits = 4'd8;
      cfg_parity    = PAR_NONE;
      cfg_stop2     = 1'b0;
      sendBit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
      rx = 1'b1;
      waitClks(BIT_CLKS / 2);
      checkOutput("mid_busy", 16'(busy), 16'h1);
      rst = 1'b1;
      waitClks(1);
      checkOutput("mid_rst_valid",   16'(rx_if.rx_valid),   16'h0);
      checkOutput("mid_rst_data",    16'(rx_if.rx_data),    16'h0);
      checkOutput("mid_rst_perr",    16'(rx_if.parity_err), 16'h0);
      checkOutput("mid_rst_ferr",    16'(rx_if.frame_err),  16'h0);
      checkOutput("mid_rst_brk",     16'(rx_if.break_det),  16'h0);
      checkOutput("mid_rst_overrun", 16'(rx_if.overrun),    16'h0);
      checkOutput("mid_rst_busy",    16'(busy),             16'h0);
      rst = 1'b0;
      waitClks(2 * BIT_CLKS);
      accepts_before = accept_count;
      applyStimulus(9'h05A, 8, PAR_NONE, 1'b0, 1'b0, -1);
      waitClks(BIT_CLKS);
      checkOutput("post_rst_accepts", 16'(accept_count - accepts_before), 16'd1);
      checkOutput("post_rst_data",    16'(cap_data), 16'h05A);
      checkOutput("post_rst_ferr",    16'(cap_ferr), 16'h0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/uart_rx_fsmd.md
# uart_rx_fsmd

Parametrised UART receiver combining the FSM and datapath into one block. Supports a runtime-selectable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits), 3-sample majority voting per bit, and an output valid/ready handshake with per-frame error flags, overrun and break detection. It sits between the pad-side `rx` line and the host/FIFO side. The baud generator outside the block supplies a `sample_tick` strobe at OVS × baud.

## Interface
Parameters:
- `DATA_MAX`, default 9: width of `rx_data`. Legal values are 5..9.
- `OVS`, default 16: sample ticks per bit. Must be even and ≥ 4.
- `CNT_W`, default $clog2(OVS): width of the in-bit tick counter.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `sample_tick`, in, 1: one-`clk` strobe at OVS × baud rate.
- `rx`, in, 1: asynchronous serial line; idles high.
- `cfg_data_bits`, in, 4: number of data bits, 5..9. Values below 5 are treated as 5; values above DATA_MAX are treated as DATA_MAX.
- `cfg_parity`, in, 2: parity mode. 00 = none, 01 = even, 10 = odd, 11 = none.
- `cfg_stop2`, in, 1: 1 selects two stop bits.
- `rx_ready`, in, 1: consumer accepts `rx_data`.
- `rx_valid`, out, 1: `rx_data` and the error flags are valid.
- `rx_data`, out, DATA_MAX: received word, LSB-aligned; unused upper bits are 0.
- `parity_err`, out, 1: parity mismatch for the held frame.
- `frame_err`, out, 1: a stop bit sampled 0 for the held frame.
- `break_det`, out, 1: held frame was all-zero (data, parity if enabled, and stop).
- `overrun`, out, 1: sticky; set when a completed frame was dropped.
- `busy`, out, 1: FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1). All FSM decisions use the synchronized value `rx_s`.
- `cnt` (CNT_W bits) counts `sample_tick` from 0 to OVS-1 within a bit. It is cleared on entry to each state.
- Majority voting: `rx_s` is sampled at cnt = OVS/2-1, OVS/2 and OVS/2+1. The bit value is the 2-of-3 majority, decided on the tick where cnt = OVS/2+1 ("decision tick").
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a tick with `rx_s` = 0. On this transition, `cfg_*` is latched; config changes mid-frame are ignored.
  - START: a decision of 1 is a false start; go back to IDLE with no output. Otherwise continue counting to OVS-1, then → DATA with bit index 0.
  - DATA: each decided bit is written to `shift[idx]`, LSB first. At the end of the bit period, `idx` increments. After bit `cfg_data_bits`-1, go → PARITY if parity is enabled, else → STOP.
  - PARITY: the decided bit is XORed with the running data parity. Error when the result is 1 in even mode, or 0 in odd mode.
  - STOP: each stop bit is decided. A 0 on any stop bit sets frame error. With `cfg_stop2`, the first stop bit runs its full period before the second. On the decision tick of the final stop bit, the frame completes and the FSM goes → IDLE immediately (half-bit early, so it can catch back-to-back frames).
- Frame completion:
  - If `rx_valid` = 0, or `rx_valid & rx_ready` is true in the same cycle, the output register loads `rx_data`, `parity_err`, `frame_err` and `break_det`, and `rx_valid` is set.
  - Otherwise the new frame is discarded, the held frame is kept unchanged, and `overrun` is set.
- Handshake: `rx_valid & rx_ready` clears `rx_valid` (unless a frame completes in the same cycle, see above) and clears `overrun`. `rx_data` and the error flags hold their values until the next load.

## Timing
- Reset values: `rx_valid` = 0, `rx_data` = 0, `parity_err` = 0, `frame_err` = 0, `break_det` = 0, `overrun` = 0, `busy` = 0. State resets to IDLE.
- Reset mid-frame aborts the frame with no output, and the synchronizer returns to 1.
- `rx_valid` rises on the `clk` edge after the final-stop decision tick, i.e. 1 `clk` of latency.
- Start detection lags the `rx` falling edge by 2 `clk` (synchronizer) plus up to one tick period.
- `busy` is high from the cycle after START entry until IDLE is re-entered.
- Ticks are ignored while `rst` is high. When `sample_tick` = 0, all counters hold.

## Structure
- Shared package `uart_rx_pkg` holds:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE` = 2'b00, `PAR_EVEN` = 2'b01, `PAR_ODD` = 2'b10.
- One sub-module, `uart_rx_sampler`, contains the synchronizer, the tick counter and the 3-sample majority voter. It outputs `bit_val`, `decide` and `bit_end` strobes. The FSM, shift register, parity tracking and output register live in `uart_rx_fsmd`.

## Test plan
- 8N1, OVS = 16, send 0xA5, `rx_ready` = 1 → one `rx_valid` pulse with `rx_data` = 0x0A5 and all error flags 0.
- 7E2, send 0x35 with a wrong parity bit of 1 → `rx_data` = 0x035, `parity_err` = 1, `frame_err` = 0.
- 8N1, `rx` low for 3 ticks only, then high → no `rx_valid`, `busy` returns to 0, FSM back in IDLE.
- `rx_ready` = 0, send 0x11 then 0x22 → `rx_data` stays 0x011 and `overrun` = 1. Raise `rx_ready` → `rx_valid` and `overrun` both clear.
- 8O1, line held low for 12 bit times → `break_det` = 1, `frame_err` = 1, `rx_data` = 0x000. A 1-tick glitch on a data bit at cnt = OVS/2 is outvoted.
- Assert `rst` during DATA bit 4 → all outputs are at reset values on the next cycle. A subsequent 0x5A frame is received correctly.
